// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer.
// Three registers sit behind Addr[3:2]: CTRL (EN, MODE, IM), PRESET and the
// read-only COUNT. A bus write always wins over the timer state machine. A
// write cycle freezes the FSM, COUNT and the interrupt flag, so software
// sees a stable snapshot while it is updating the registers.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  // Register indices within the 16-byte window (Addr[3:2]).
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;
  localparam int         NUM_REGS    = 4;

  // MODE encoding: only 00 is one-shot; every other value auto-reloads.
  localparam logic [1:0] MODE_ONE_SHOT = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;

  logic        ctrl_en_q, ctrl_en_d;
  logic [1:0]  ctrl_mode_q, ctrl_mode_d;
  logic        ctrl_im_q, ctrl_im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  // Address decode and write strobes.
  logic [1:0]          reg_sel;
  logic [NUM_REGS-1:0] sel_onehot;
  logic                wr_ctrl;
  logic                wr_preset;

  // FSM helpers.
  logic        fsm_active;
  logic        one_shot;
  logic        count_expired;
  logic [31:0] count_dec;
  logic        fsm_clear_en;

  // Read path.
  logic [31:0] rd_word [NUM_REGS];
  logic [31:0] ctrl_word;

  // Only Addr[3:2] selects a register; the bridge has already done the
  // window decode, so the remaining address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Addr[31:4], Addr[1:0]};

  assign reg_sel = Addr[3:2];

  // One-hot register select, one decoder term per register slot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_sel
      assign sel_onehot[gi] = (reg_sel == 2'(gi));
    end
  endgenerate

  // Writes to COUNT and to the reserved slot have no storage target. They
  // still freeze the FSM, because that freeze is keyed on WE alone.
  assign wr_ctrl   = WE & sel_onehot[ADDR_CTRL];
  assign wr_preset = WE & sel_onehot[ADDR_PRESET];

  // The state machine only advances on cycles without a bus write.
  assign fsm_active = ~WE;

  assign one_shot      = (ctrl_mode_q == MODE_ONE_SHOT);
  // COUNT <= 1 ends the run. PRESET = 0 and PRESET = 1 therefore both take
  // exactly one CNT cycle, and COUNT never wraps below zero.
  assign count_expired = (count_q <= 32'd1);
  assign count_dec     = count_q - 32'd1;

  // Next-state, COUNT and irq_flag: defaults hold everything, and the FSM
  // overrides them only on non-write cycles.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    irq_flag_d   = irq_flag_q;
    fsm_clear_en = 1'b0;
    if (fsm_active) begin
      case (state_q)
        S_IDLE: begin
          // Leaving IDLE is the only place a pending one-shot flag clears.
          if (ctrl_en_q) begin
            state_d    = S_LOAD;
            irq_flag_d = 1'b0;
          end
        end
        S_LOAD: begin
          count_d = preset_q;
          state_d = S_CNT;
        end
        S_CNT: begin
          if (!ctrl_en_q) begin
            // Disable freezes COUNT. A later enable reloads from PRESET.
            state_d = S_IDLE;
          end else if (count_expired) begin
            count_d    = 32'd0;
            irq_flag_d = 1'b1;
            state_d    = S_INT;
          end else begin
            count_d = count_dec;
          end
        end
        S_INT: begin
          state_d = S_IDLE;
          if (one_shot) begin
            // One-shot disarms itself and leaves the flag pending.
            fsm_clear_en = 1'b1;
          end else begin
            // Auto-reload: the flag is a single-cycle pulse. EN is still
            // set, so IDLE immediately starts the next period.
            irq_flag_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // CTRL and PRESET next values: a bus write has priority over the FSM's
  // self-clear of EN. The two can never coincide because the FSM is frozen
  // on write cycles.
  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    ctrl_mode_d = ctrl_mode_q;
    ctrl_im_d   = ctrl_im_q;
    preset_d    = preset_q;
    if (wr_ctrl) begin
      ctrl_en_d   = Din[0];
      ctrl_mode_d = Din[2:1];
      ctrl_im_d   = Din[3];
    end else if (fsm_clear_en) begin
      ctrl_en_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = Din;
    end
  end

  // State and register storage with immediate asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ctrl_en_q   <= 1'b0;
      ctrl_mode_q <= 2'b00;
      ctrl_im_q   <= 1'b0;
      preset_q    <= 32'd0;
      count_q     <= 32'd0;
      irq_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_en_q   <= ctrl_en_d;
      ctrl_mode_q <= ctrl_mode_d;
      ctrl_im_q   <= ctrl_im_d;
      preset_q    <= preset_d;
      count_q     <= count_d;
      irq_flag_q  <= irq_flag_d;
    end
  end

  // Read words for each slot. The reserved slot always reads zero.
  assign ctrl_word             = {28'd0, ctrl_im_q, ctrl_mode_q, ctrl_en_q};
  assign rd_word[ADDR_CTRL]    = ctrl_word;
  assign rd_word[ADDR_PRESET]  = preset_q;
  assign rd_word[ADDR_COUNT]   = count_q;
  assign rd_word[ADDR_RSVD]    = 32'd0;

  // Combinational read mux, valid in the same cycle as Addr.
  always_comb begin
    Dout = rd_word[reg_sel];
  end

  // Masking only hides the interrupt. The flag itself stays pending.
  assign IRQ = ctrl_im_q & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Randomized and directed bench for timer_counter, checked against a
// timeline-based reference model of the timer.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_total = 0;
  int n_bad   = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. A run is tracked as a position on a timeline:
  // m_active=0 means idle. m_step=0 is the load slot. Steps 1..run_len are
  // count slots. The step after that is the interrupt slot.
  bit          m_en, m_im, m_irq, m_active;
  bit  [1:0]   m_mode;
  logic [31:0] m_preset, m_count, m_plat;
  int          m_step;

  task automatic model_reset();
    m_en = 0; m_im = 0; m_irq = 0; m_active = 0; m_mode = 2'b00;
    m_preset = 32'd0; m_count = 32'd0; m_plat = 32'd0; m_step = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_tick(input logic we, input logic [1:0] a, input logic [31:0] d);
    longint run_len;
    longint remain;
    if (we) begin
      if (a == 2'd0) begin
        m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
      end else if (a == 2'd1) begin
        m_preset = d;
      end
      return;
    end
    if (!m_active) begin
      if (m_en) begin
        m_active = 1; m_step = 0; m_irq = 0;
      end
    end else if (m_step == 0) begin
      m_plat = m_preset; m_count = m_preset; m_step = 1;
    end else begin
      run_len = (m_plat == 32'd0) ? 64'd1 : longint'(m_plat);
      if (longint'(m_step) <= run_len) begin
        if (!m_en) begin
          m_active = 0;
        end else begin
          remain  = longint'(m_plat) - longint'(m_step);
          m_count = (remain > 0) ? remain[31:0] : 32'd0;
          if (longint'(m_step) == run_len) m_irq = 1;
          m_step++;
        end
      end else begin
        if (m_mode == 2'b00) m_en = 0;
        else m_irq = 0;
        m_active = 0;
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs on the falling edge, check the combinational
  // outputs against the model, then advance the model to the next edge.
  task automatic cyc(input logic we, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] ad;
    @(negedge clk);
    ad      = $urandom;
    ad[3:2] = a;
    Addr = ad; WE = we; Din = d;
    #1;
    check_val("dout", Dout, model_read(a));
    check_val("irq", {31'd0, IRQ}, {31'd0, m_im & m_irq});
    $display("cyc t=%0t we=%0b a=%0d din=0x%08h dout=0x%08h irq=%0b", $time, we, a, d, Dout, IRQ);
    model_tick(we, a, d);
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) cyc(1'b0, a, 32'd0);
  endtask

  int          pulses;
  logic [1:0]  ra;
  logic [31:0] rd;
  logic        rwe;

  initial begin
    model_reset();
    reset = 1'b1; WE = 1'b0; Addr = 32'd0; Din = 32'd0;
    #1;
    check_val("rst0_irq", {31'd0, IRQ}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) cyc(1'b0, 2'(a), 32'd0);

    // One-shot, PRESET=3, IM=1.
    cyc(1'b1, 2'd1, 32'd3);
    cyc(1'b1, 2'd0, 32'h9);
    idle(8, 2'd2);
    cyc(1'b0, 2'd0, 32'd0);
    check_val("os_ctrl", Dout, 32'h8);
    check_val("os_irq", {31'd0, IRQ}, 32'd1);
    cyc(1'b1, 2'd0, 32'h9);
    idle(3, 2'd2);
    cyc(1'b1, 2'd0, 32'h0);
    idle(8, 2'd2);

    // Auto-reload, PRESET=2: one IRQ pulse every 5 cycles.
    cyc(1'b1, 2'd1, 32'd2);
    cyc(1'b1, 2'd0, 32'hB);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 2'd2, 32'd0);
      if (IRQ) pulses++;
    end
    check_val("ar_pulses", pulses, 32'd3);
    cyc(1'b0, 2'd0, 32'd0);
    check_val("ar_ctrl", Dout, 32'hB);
    cyc(1'b1, 2'd0, 32'h0);
    idle(6, 2'd2);

    // Masked one-shot, then expose the pending flag.
    cyc(1'b1, 2'd1, 32'd1);
    cyc(1'b1, 2'd0, 32'h1);
    idle(6, 2'd2);
    check_val("mask_irq", {31'd0, IRQ}, 32'd0);
    cyc(1'b1, 2'd0, 32'h8);
    cyc(1'b0, 2'd0, 32'd0);
    check_val("unmask_irq", {31'd0, IRQ}, 32'd1);

    // Write freeze mid-count.
    cyc(1'b1, 2'd1, 32'd20);
    cyc(1'b1, 2'd0, 32'h1);
    for (int i = 0; i < 40 && m_count != 32'd10; i++) cyc(1'b0, 2'd2, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd1, 32'h55);
    cyc(1'b0, 2'd2, 32'd0);
    check_val("frz_cnt10", Dout, 32'd10);
    cyc(1'b0, 2'd2, 32'd0);
    check_val("frz_cnt9", Dout, 32'd9);

    // CTRL stores Din[3:0] only. Reserved reads 0. COUNT is read-only.
    cyc(1'b1, 2'd0, 32'hFFFF_FFFF);
    cyc(1'b0, 2'd0, 32'd0);
    check_val("ctrl_f", Dout, 32'hF);
    cyc(1'b0, 2'd3, 32'd0);
    check_val("rsvd", Dout, 32'd0);
    cyc(1'b1, 2'd2, 32'h1234);
    idle(3, 2'd2);

    // Asynchronous reset in the middle of a count.
    cyc(1'b1, 2'd0, 32'h0);
    idle(4, 2'd2);
    cyc(1'b1, 2'd1, 32'd8);
    cyc(1'b1, 2'd0, 32'h9);
    for (int i = 0; i < 20 && m_count != 32'd5; i++) cyc(1'b0, 2'd2, 32'd0);
    cyc(1'b0, 2'd2, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_irq", {31'd0, IRQ}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      Addr = {26'd0, 2'(a), 2'b00};
      #0.5;
      check_val("arst_dout", Dout, 32'd0);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(5, 2'd2);
    cyc(1'b0, 2'd0, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rwe = ($urandom_range(0, 7) == 0);
      ra  = 2'($urandom_range(0, 3));
      if (rwe && ra == 2'd1) rd = $urandom_range(0, 6);
      else if (rwe && ra == 2'd0) rd = {$urandom, 1'b1} >> ($urandom_range(0, 3) == 0);
      else rd = $urandom;
      cyc(rwe, ra, rd);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped 32-bit down-counting timer; sits directly downstream of the CPU system bridge.
- Two instances are used, one in each timer window (0x0000_7F00–0x0000_7F0B and 0x0000_7F10–0x0000_7F1B).
- The bridge does the window decode and supplies address, write enable and write data. This block returns read data and an interrupt request to the CPU's interrupt inputs.

Parameters:
- None. Register width is fixed at 32 bits. The register map is fixed.

Ports:
- clk    input   1   system clock; all state updates on rising edge
- reset  input   1   asynchronous, active-high reset
- Addr   input   32  byte address from the bridge; only Addr[3:2] is decoded
- WE     input   1   write enable, already qualified by the bridge for this window
- Din    input   32  write data
- Dout   output  32  read data, combinational from Addr[3:2]
- IRQ    output  1   interrupt request, level

Behaviour:
- Register map, selected by Addr[3:2]:
  - 0 = CTRL (read/write).
  - 1 = PRESET (read/write).
  - 2 = COUNT (read-only).
  - 3 = reserved: reads 0, writes ignored.
- CTRL fields:
  - bit0 EN (enable).
  - bits[2:1] MODE: 00 = one-shot, 01/10/11 = auto-reload.
  - bit3 IM (interrupt mask; 1 = IRQ may assert).
  - bits[31:4] always read 0. A write stores Din[3:0] only.
- Reset (asynchronous, immediate) clears:
  - CTRL, PRESET and COUNT to 0.
  - Internal irq_flag to 0.
  - state to IDLE.
  - Consequently IRQ = 0 and Dout = 0 for all addresses while reset is held.
- Register writes and the state machine:
  - Any cycle with WE = 1 performs the register write. The state machine, COUNT and irq_flag hold their values that cycle (the write has priority and freezes the FSM).
  - A write to COUNT or to address 3 is a no-op, but it still freezes the FSM for that cycle.
- State machine (evaluated only on cycles with WE = 0):
  - IDLE:
    - EN = 1 -> LOAD, and irq_flag <= 0.
    - Otherwise stay in IDLE.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT:
    - EN = 0 -> IDLE; COUNT holds.
    - EN = 1 and COUNT > 1 -> COUNT <= COUNT - 1; stay in CNT.
    - EN = 1 and COUNT <= 1 -> COUNT <= 0, irq_flag <= 1 -> INT.
  - INT:
    - MODE = 00 -> CTRL.EN <= 0 -> IDLE. irq_flag stays 1 until EN is rewritten to 1 and IDLE exits.
    - MODE != 00 -> irq_flag <= 0 -> IDLE. The timer reloads and restarts automatically because EN is still 1.
- IRQ = CTRL.IM & irq_flag:
  - Combinational.
  - Masking hides the interrupt but does not clear irq_flag, so setting IM later exposes a pending one-shot interrupt.
- Timing with PRESET = N >= 1, EN set at cycle t (the write cycle):
  - IDLE at t+1, LOAD at t+2.
  - COUNT = N visible after t+2; COUNT reaches 0 after t+2+N.
  - irq_flag rises with the INT entry.
  - Auto-reload: irq_flag is high for exactly one cycle. The period is N+3 cycles (INT, IDLE, LOAD, then N counts).
- Boundary cases:
  - PRESET = 0 or 1: goes LOAD -> CNT -> INT after one CNT cycle; COUNT = 0.
  - Writing PRESET mid-count does not affect COUNT until the next LOAD.
  - Clearing EN mid-count freezes COUNT. Re-enabling reloads from PRESET; it does not resume.
  - Arithmetic is unsigned 32-bit. COUNT never wraps below 0.
- Dout is combinational and is valid in the same cycle as Addr: CTRL returns {28'b0, IM, MODE, EN}.

Test Plan:
- Reset asserted mid-count (COUNT = 5, state CNT) -> COUNT, CTRL, PRESET and IRQ go to 0 immediately without a clock edge; after release, state is IDLE and nothing counts.
- PRESET = 3; write CTRL = 0x9 (IM = 1, one-shot, EN = 1) -> COUNT reads 3, 2, 1, 0 on successive cycles after LOAD. IRQ goes 1 on INT entry and stays 1. CTRL then reads 0x8 (EN self-cleared). A fresh CTRL write of 0x9 drops IRQ one cycle later, on IDLE exit.
- PRESET = 2; CTRL = 0xB (auto-reload, IM = 1, EN = 1) -> IRQ is a 1-cycle pulse every 5 cycles. COUNT sequence repeats 2, 1, 0. CTRL.EN stays 1.
- CTRL = 0x1 (IM = 0), PRESET = 1 -> irq_flag sets but IRQ stays 0. Then write CTRL = 0x8 -> IRQ becomes 1 (pending one-shot exposed).
- While counting with COUNT = 10, hold WE = 1 writing PRESET = 0x55 for 3 cycles -> COUNT stays 10 for those 3 cycles, then resumes decrementing from 10, not from 0x55. Write Din = 0xFFFF_FFFF to CTRL -> CTRL reads 0x0000_000F.
- Read Addr[3:2] = 3 -> Dout = 0. Write COUNT with 0x1234 -> COUNT unchanged.
